// File: rtl/pack_phrase.sv
// Word-to-phrase packer: gathers WORDS input words into one wide phrase with a keep mask and a frame-start flag.
// Short phrases (line end or mid-phrase frame start) are padded with PAD_WORD.
module pack_phrase #(
    parameter int                WORD_W   = 16,
    parameter int                WORDS    = 8,
    parameter logic [WORD_W-1:0] PAD_WORD = '0
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [WORD_W-1:0]       data_in,
    input  logic                    newframe_in,
    input  logic                    last_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [WORD_W*WORDS-1:0] data_out,
    output logic [WORDS-1:0]        tkeep_out,
    output logic                    tuser_out
);

    localparam int PHRASE_W = WORD_W * WORDS;
    localparam int CW       = $clog2(WORDS + 1);
    localparam int IW       = $clog2(WORDS);

    typedef logic [WORDS-1:0][WORD_W-1:0] slots_t;

    // Slot 0 lands in the top field; slots at or above the fill count read as padding.
    function automatic logic [PHRASE_W-1:0] pack_slots(input slots_t s, input logic [CW-1:0] n);
        logic [PHRASE_W-1:0] p;
        p = '0;
        for (int k = 0; k < WORDS; k++) begin
            p[WORD_W*(WORDS-k)-1 -: WORD_W] = (CW'(k) < n) ? s[k] : PAD_WORD;
        end
        return p;
    endfunction

    function automatic logic [WORDS-1:0] keep_mask(input logic [CW-1:0] n);
        logic [WORDS-1:0] m;
        for (int k = 0; k < WORDS; k++) begin
            m[k] = (CW'(k) < n);
        end
        return m;
    endfunction

    slots_t                a_slot_q, a_slot_d;
    logic [CW-1:0]         a_cnt_q, a_cnt_d;
    logic                  a_user_q, a_user_d;
    logic                  a_closed_q, a_closed_d;
    logic [WORD_W-1:0]     h_data_q, h_data_d;
    logic                  h_last_q, h_last_d;
    logic                  h_vld_q, h_vld_d;
    logic                  o_vld_q, o_vld_d;
    logic [PHRASE_W-1:0]   o_data_q, o_data_d;
    logic [WORDS-1:0]      o_keep_q, o_keep_d;
    logic                  o_user_q, o_user_d;
    logic                  rdy_q, rdy_d;

    logic                  o_free;
    logic                  accept;
    logic [IW-1:0]         wr_idx;
    slots_t                ins_slot;
    logic [CW-1:0]         ins_cnt;
    logic                  first_user;
    logic                  ld;
    slots_t                ld_slots;
    logic [CW-1:0]         ld_cnt;
    logic                  ld_user;

    assign o_free = !o_vld_q || ready_out;
    assign accept = valid_in && rdy_q;
    assign wr_idx = a_cnt_q[IW-1:0];

    always_comb begin
        a_slot_d   = a_slot_q;
        a_cnt_d    = a_cnt_q;
        a_user_d   = a_user_q;
        a_closed_d = a_closed_q;
        h_data_d   = h_data_q;
        h_last_d   = h_last_q;
        h_vld_d    = h_vld_q;
        o_vld_d    = o_vld_q;
        o_data_d   = o_data_q;
        o_keep_d   = o_keep_q;
        o_user_d   = o_user_q;

        ins_slot         = a_slot_q;
        ins_slot[wr_idx] = data_in;
        ins_cnt          = a_cnt_q + CW'(1);
        first_user       = (a_cnt_q == '0) ? newframe_in : a_user_q;

        ld       = 1'b0;
        ld_slots = a_slot_q;
        ld_cnt   = a_cnt_q;
        ld_user  = a_user_q;

        if (o_free) begin
            o_vld_d = 1'b0;
        end

        if (a_closed_q) begin
            if (o_free) begin
                ld         = 1'b1;
                a_cnt_d    = '0;
                a_user_d   = 1'b0;
                a_closed_d = 1'b0;
                // A word parked behind a closed partial always starts a frame.
                if (h_vld_q) begin
                    a_slot_d[0] = h_data_q;
                    a_cnt_d     = CW'(1);
                    a_user_d    = 1'b1;
                    a_closed_d  = h_last_q;
                    h_vld_d     = 1'b0;
                end
            end
        end else if (accept) begin
            if (newframe_in && (a_cnt_q != '0)) begin
                if (o_free) begin
                    ld          = 1'b1;
                    a_slot_d[0] = data_in;
                    a_cnt_d     = CW'(1);
                    a_user_d    = 1'b1;
                    a_closed_d  = last_in;
                end else begin
                    a_closed_d = 1'b1;
                    h_data_d   = data_in;
                    h_last_d   = last_in;
                    h_vld_d    = 1'b1;
                end
            end else if ((a_cnt_q == CW'(WORDS-1)) || last_in) begin
                if (o_free) begin
                    ld       = 1'b1;
                    ld_slots = ins_slot;
                    ld_cnt   = ins_cnt;
                    ld_user  = first_user;
                    a_cnt_d  = '0;
                    a_user_d = 1'b0;
                end else begin
                    a_slot_d   = ins_slot;
                    a_cnt_d    = ins_cnt;
                    a_user_d   = first_user;
                    a_closed_d = 1'b1;
                end
            end else begin
                a_slot_d = ins_slot;
                a_cnt_d  = ins_cnt;
                a_user_d = first_user;
            end
        end

        if (ld) begin
            o_vld_d  = 1'b1;
            o_data_d = pack_slots(ld_slots, ld_cnt);
            o_keep_d = keep_mask(ld_cnt);
            o_user_d = ld_user;
        end

        // Registered so ready_in never depends combinationally on valid_in or ready_out.
        rdy_d = !a_closed_d && !h_vld_d;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_cnt_q    <= '0;
            a_user_q   <= 1'b0;
            a_closed_q <= 1'b0;
            h_last_q   <= 1'b0;
            h_vld_q    <= 1'b0;
            o_vld_q    <= 1'b0;
            o_data_q   <= '0;
            o_keep_q   <= '0;
            o_user_q   <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            a_cnt_q    <= a_cnt_d;
            a_user_q   <= a_user_d;
            a_closed_q <= a_closed_d;
            h_last_q   <= h_last_d;
            h_vld_q    <= h_vld_d;
            o_vld_q    <= o_vld_d;
            o_data_q   <= o_data_d;
            o_keep_q   <= o_keep_d;
            o_user_q   <= o_user_d;
            rdy_q      <= rdy_d;
        end
    end

    // Word storage needs no reset: the fill count masks stale slots.
    always_ff @(posedge clk_in) begin
        a_slot_q <= a_slot_d;
        h_data_q <= h_data_d;
    end

    assign ready_in  = rdy_q;
    assign valid_out = o_vld_q;
    assign data_out  = o_data_q;
    assign tkeep_out = o_keep_q;
    assign tuser_out = o_user_q;

endmodule
